vram_rect_fill: RTL and testbench

VRAM_RECT_FILL -- requirements
Module: vram_rect_fill

---
 rtl/vram_pkg.sv | 22 ++
 rtl/rect_scan_counter.sv | 35 +++
 rtl/vram_rect_fill.sv | 109 ++++++++++
 tb/tb_vram_rect_fill.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM geometry, FSM states and fill command layout for vram_rect_fill
package vram_pkg;
  localparam int VRAM_W     = 512;
  localparam int VRAM_H     = 128;
  localparam int X_BITS     = 9;
  localparam int Y_BITS     = 7;
  localparam int COLOR_BITS = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [X_BITS-1:0]     x0;
    logic [Y_BITS-1:0]     y0;
    logic [9:0]            w;
    logic [7:0]            h;
    logic [COLOR_BITS-1:0] color;
  } fill_cmd_t;
endpackage

// File: rtl/rect_scan_counter.sv
// rect_scan_counter: row-major x/y offset counters with next-pixel offsets and a last-pixel flag
module rect_scan_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_advance,
  input  logic [9:0] i_w,
  input  logic [7:0] i_h,
  output logic [9:0] o_x_nxt,
  output logic [7:0] o_y_nxt,
  output logic       o_last
);
  logic [9:0] r_x;
  logic [7:0] r_y;
  logic       w_eol;

  assign w_eol   = r_x == i_w - 10'd1;
  assign o_x_nxt = w_eol ? 10'd0 : r_x + 10'd1;
  assign o_y_nxt = w_eol ? r_y + 8'd1 : r_y;
  assign o_last  = w_eol && (r_y == i_h - 8'd1);

  // offsets name the pixel currently on the write port; start points them at (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      r_x <= o_x_nxt;
      r_y <= o_y_nxt;
    end
  end
endmodule

// File: rtl/vram_rect_fill.sv
// vram_rect_fill: rectangle fill engine, one VRAM pixel write per cycle in row-major order.
// Define VRAM_RECT_FILL_CLIP_EN to suppress writes outside the 512x128 surface instead of wrapping.
module vram_rect_fill
  import vram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_BITS-1:0]     cmd_x0,
  input  logic [Y_BITS-1:0]     cmd_y0,
  input  logic [9:0]            cmd_w,
  input  logic [7:0]            cmd_h,
  input  logic [COLOR_BITS-1:0] cmd_color,
  input  logic                  abort,
  output logic [15:0]           vram_write_addr,
  output logic [15:0]           vram_write_data,
  output logic                  vram_write_en,
  output logic                  busy,
  output logic                  done
);
`ifdef VRAM_RECT_FILL_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  state_t    r_state;
  fill_cmd_t r_cmd;
  logic      r_ready, r_busy, r_done, r_we;
  logic [15:0] r_addr, r_data;
  logic       w_accept, w_advance, w_last, w_wr;
  logic [9:0] w_ox_nxt, w_x;
  logic [7:0] w_oy_nxt, w_y;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign w_advance = (r_state == S_FILL) && !abort && !w_last;
  assign w_x       = {1'b0, r_cmd.x0} + w_ox_nxt;
  assign w_y       = {1'b0, r_cmd.y0} + w_oy_nxt;
  assign w_wr      = !(CLIP && (w_x[9] || w_y[7]));

  rect_scan_counter u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_accept),
    .i_advance(w_advance),
    .i_w      (r_cmd.w),
    .i_h      (r_cmd.h),
    .o_x_nxt  (w_ox_nxt),
    .o_y_nxt  (w_oy_nxt),
    .o_last   (w_last)
  );

  assign cmd_ready       = r_ready;
  assign busy            = r_busy;
  assign done            = r_done;
  assign vram_write_en   = r_we;
  assign vram_write_addr = r_addr;
  assign vram_write_data = r_data;

  // FSM with registered outputs; the accepting edge already presents pixel (x0,y0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_cmd   <= {cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color};
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          if (cmd_w == '0 || cmd_h == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_FILL;
            r_we    <= 1'b1;
            r_addr  <= {cmd_y0, cmd_x0};
            r_data  <= {{(16-COLOR_BITS){1'b0}}, cmd_color};
          end
        end
        S_FILL: if (abort || w_last) begin
          r_state <= S_DONE;
          r_we    <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_we <= w_wr;
          if (w_wr) begin
            r_addr <= {w_y[6:0], w_x[8:0]};
            r_data <= {{(16-COLOR_BITS){1'b0}}, r_cmd.color};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_rect_fill.sv
// tb_vram_rect_fill: table-driven and scoreboard checks of vram_rect_fill
module tb_vram_rect_fill;
  logic        clk = 1'b0, rst_n = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
  logic [8:0]  cmd_x0 = '0;
  logic [6:0]  cmd_y0 = '0;
  logic [9:0]  cmd_w = '0;
  logic [7:0]  cmd_h = '0;
  logic [2:0]  cmd_color = '0;
  logic        cmd_ready, vram_write_en, busy, done;
  logic [15:0] vram_write_addr, vram_write_data;

  vram_rect_fill dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .abort(abort), .vram_write_addr(vram_write_addr), .vram_write_data(vram_write_data),
    .vram_write_en(vram_write_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;
  typedef struct { int x0, y0, w, h, color, exp_nc, exp_clip; } vec_t;

  wr_t q[$];
  int  done_at[$];
  int  n_chk = 0, n_err = 0, cyc = 0, nwr = 0;
  vec_t vt[7];

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (vram_write_en === 1'b1) begin
      nwr++;
      if (q.size() == 0) chk("extra_write", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("wr_addr", int'(vram_write_addr), int'(e.a));
        chk("wr_data", int'(vram_write_data), int'(e.d));
      end
    end
    if (done === 1'b1) done_at.push_back(cyc);
  endtask

  function automatic void push_exp(int x0, int y0, int w, int h, int color);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++) begin
        int x = (x0 + i) % 1024;
        int y = (y0 + j) % 256;
        bit wr = 1'b1;
`ifdef VRAM_RECT_FILL_CLIP_EN
        wr = (x < 512) && (y < 128);
`endif
        if (wr) q.push_back(wr_t'{a: 16'((y % 128) * 512 + (x % 512)), d: 16'(color)});
      end
  endfunction

  task automatic drive(int x0, int y0, int w, int h, int color);
    cmd_x0 = 9'(x0); cmd_y0 = 7'(y0); cmd_w = 10'(w); cmd_h = 8'(h); cmd_color = 3'(color);
    cmd_valid = 1'b1;
  endtask

  task automatic run_cmd(int x0, int y0, int w, int h, int color, int exp_wr);
    for (int t = 0; t < 8 && cmd_ready !== 1'b1; t++) tick();
    chk("ready_before", cmd_ready, 1);
    q.delete(); done_at.delete(); nwr = 0; cyc = 0;
    push_exp(x0, y0, w, h, color);
    drive(x0, y0, w, h, color);
    tick();
    cmd_valid = 1'b0;
    chk("busy_on_accept", busy, 1);
    chk("ready_low", cmd_ready, 0);
    while (done_at.size() == 0 && cyc < w * h + 8) tick();
    chk("done_cycle", done_at.size() != 0 ? done_at[0] : -1, w * h + 1);
    chk("write_count", nwr, exp_wr);
    chk("queue_drained", q.size(), 0);
    tick();
    chk("ready_after", cmd_ready, 1);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{10, 5, 3, 2, 1, 6, 6};
    vt[1] = '{0, 0, 0, 7, 2, 0, 0};
    vt[2] = '{510, 127, 4, 2, 5, 8, 2};
    vt[3] = '{0, 0, 1, 1, 7, 1, 1};
    vt[4] = '{5, 9, 4, 0, 3, 0, 0};
    vt[5] = '{500, 10, 20, 3, 6, 60, 36};
    vt[6] = '{511, 127, 1, 1, 4, 1, 1};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", vram_write_en, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", int'(vram_write_addr), 0);
    chk("rst_data", int'(vram_write_data), 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 7; i++) begin
`ifdef VRAM_RECT_FILL_CLIP_EN
      run_cmd(vt[i].x0, vt[i].y0, vt[i].w, vt[i].h, vt[i].color, vt[i].exp_clip);
`else
      run_cmd(vt[i].x0, vt[i].y0, vt[i].w, vt[i].h, vt[i].color, vt[i].exp_nc);
`endif
    end

    // abort with cmd_valid in IDLE is accepted; abort on the 3rd pixel of 100x1 stops after 3 writes
    q.delete(); done_at.delete(); nwr = 0; cyc = 0;
    push_exp(100, 3, 3, 1, 2);
    drive(100, 3, 100, 1, 2);
    abort = 1'b1;
    tick();
    cmd_valid = 1'b0; abort = 1'b0;
    chk("abort_idle_accept", vram_write_en, 1);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_we_off", vram_write_en, 0);
    chk("abort_done", done, 1);
    chk("abort_writes", nwr, 3);
    chk("abort_queue", q.size(), 0);
    tick();
    chk("abort_ready", cmd_ready, 1);

    // reset mid-fill
    q.delete(); done_at.delete(); nwr = 0; cyc = 0;
    push_exp(0, 20, 5, 1, 6);
    drive(0, 20, 50, 1, 6);
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    chk("rst_mid_writes", nwr, 5);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", vram_write_en, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_addr", int'(vram_write_addr), 0);
    chk("rst_mid_done", done, 0);
    tick();
    rst_n = 1'b1;
    nwr = 0; done_at.delete();
    tick();
    chk("rst_mid_ready", cmd_ready, 1);
    repeat (3) tick();
    chk("rst_mid_no_done", done_at.size(), 0);
    chk("rst_mid_no_write", nwr, 0);

    // cmd_valid held high across two back-to-back commands
    q.delete(); done_at.delete(); nwr = 0; cyc = 0;
    push_exp(10, 5, 3, 2, 1);
    push_exp(20, 6, 2, 2, 4);
    drive(10, 5, 3, 2, 1);
    tick();
    drive(20, 6, 2, 2, 4);
    while (done_at.size() < 2 && cyc < 40) tick();
    cmd_valid = 1'b0;
    chk("b2b_done1", done_at.size() > 0 ? done_at[0] : -1, 7);
    chk("b2b_done2", done_at.size() > 1 ? done_at[1] : -1, 13);
    chk("b2b_writes", nwr, 10);
    chk("b2b_queue", q.size(), 0);
    tick();
    chk("b2b_ready", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
